// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write/status/line bundle for the buffered 8N1 transmitter
//
// Signals:
//   wr_en, wr_data  push one byte into the transmit FIFO
//   full, empty     FIFO occupancy flags derived from count
//   count           bytes queued, excluding the byte on the line
//   overflow        sticky: a write was attempted while full
//   busy            a frame is on the line or bytes are queued
//   tx              serial line, idle high
// Modports: master drives writes and observes status; slave is the transmitter.

interface uart_tx_fifo_if #(
    parameter int BUFFER_SIZE = 32
);
    localparam int COUNT_W = $clog2(BUFFER_SIZE + 1);

    logic               wr_en;
    logic [7:0]         wr_data;
    logic               full;
    logic               empty;
    logic [COUNT_W-1:0] count;
    logic               overflow;
    logic               busy;
    logic               tx;

    modport master (
        output wr_en,
        output wr_data,
        input  full,
        input  empty,
        input  count,
        input  overflow,
        input  busy,
        input  tx
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output full,
        output empty,
        output count,
        output overflow,
        output busy,
        output tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a back-to-back 8N1 UART transmitter
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   uart_tx_fifo_if.slave: wr_en/wr_data in; full/empty/count/overflow/busy/tx out
// Parameters: CLOCK_FREQ and BAUD_RATE set CLKS_PER_BIT (>= 2); BUFFER_SIZE is a
// power of two >= 2.

module uart_tx_fifo #(
    parameter int CLOCK_FREQ  = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int BUFFER_SIZE = 32
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int PTR_W        = $clog2(BUFFER_SIZE);
    localparam int CNT_W        = $clog2(BUFFER_SIZE + 1);
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             full_w;
    logic             empty_w;
    logic             push;
    logic             pop;

    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);

    // A write while full is dropped even if a pop frees a slot this same
    // cycle, because acceptance looks at the registered full flag.
    assign push = bus.wr_en && !full_w;

    // Storage needs no reset; stale contents are never read past count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (bus.wr_en && full_w) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_next;
    logic [7:0]        shift;
    logic [7:0]        shift_next;
    logic              tx_q;
    logic              tx_next;
    logic              baud_done;

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!empty_w) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done && (bit_idx == 3'd7)) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Chaining straight into START keeps queued frames gap-free.
                if (baud_done) begin
                    state_next = empty_w ? S_IDLE : S_START;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        baud_next  = baud_cnt + BAUD_W'(1);
        bit_next   = bit_idx;
        shift_next = shift;
        case (state)
            S_IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                if (!empty_w) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_next = '0;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = bit_idx + 3'd1;
                    shift_next = {1'b0, shift[7:1]};
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    bit_next  = '0;
                    if (!empty_w) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                    end
                end
            end
            default: begin
                baud_next = '0;
                bit_next  = '0;
            end
        endcase

        // tx is registered, so its level is chosen from where the FSM is
        // going; the line then changes on the same edge as the state.
        case (state_next)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            tx_q     <= tx_next;
        end
    end

    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state != S_IDLE) || !empty_w;
    assign bus.tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo

module tb_uart_tx_fifo;
    localparam int CF    = 1_000_000;
    localparam int BR    = 100_000;
    localparam int BS    = 4;
    localparam int CPB   = CF / BR;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.BUFFER_SIZE(BS)) bus ();

    uart_tx_fifo #(
        .CLOCK_FREQ (CF),
        .BAUD_RATE  (BR),
        .BUFFER_SIZE(BS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: queue of waiting bytes, the byte on the line and how
    // many cycles of its 10-bit frame remain (0 means line idle).
    logic [7:0] m_q[$];
    logic [7:0] m_cur  = 8'h00;
    int         m_left = 0;
    logic       m_ovf  = 1'b0;
    logic [7:0] sent_q[$];

    // Independent line decoder sampling each bit at its midpoint.
    int         dec_idx  = -1;
    logic [7:0] dec_byte = 8'h00;
    logic [7:0] dec_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_tx();
        int b;
        if (m_left == 0) return 1'b1;
        b = (FRAME - m_left) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    task automatic step();
        logic       r;
        logic       we;
        logic [7:0] wd;
        bit         pre_full;
        bit         do_pop;
        logic [31:0] exp_b;
        int         b;
        @(posedge clk);
        r  = rst;
        we = bus.wr_en;
        wd = bus.wr_data;
        if (r) begin
            m_q.delete();
            sent_q.delete();
            m_left = 0;
            m_ovf  = 1'b0;
        end else begin
            pre_full = (m_q.size() == BS);
            do_pop   = (m_q.size() != 0) && (m_left <= 1);
            if (we && pre_full) m_ovf = 1'b1;
            if (m_left > 0) m_left--;
            if (do_pop) begin
                m_cur  = m_q.pop_front();
                m_left = FRAME;
                sent_q.push_back(m_cur);
            end
            if (we && !pre_full) m_q.push_back(wd);
        end
        #1;
        chk("tx", bus.tx, exp_tx());
        chk("count", bus.count, m_q.size());
        chk("full", bus.full, m_q.size() == BS);
        chk("empty", bus.empty, m_q.size() == 0);
        chk("busy", bus.busy, (m_left > 0) || (m_q.size() != 0));
        chk("overflow", bus.overflow, m_ovf);

        if (r) begin
            dec_idx = -1;
        end else begin
            if (dec_idx >= 0) begin
                dec_idx++;
                if (dec_idx == FRAME) begin
                    dec_log.push_back(dec_byte);
                    exp_b = (sent_q.size() > 0) ? 32'(sent_q.pop_front()) : 32'hFFFF_FFFF;
                    chk("decoded", dec_byte, exp_b);
                    dec_idx = -1;
                end
            end
            if (dec_idx < 0) begin
                if (bus.tx === 1'b0) dec_idx = 0;
            end else if (dec_idx % CPB == CPB / 2) begin
                b = dec_idx / CPB;
                if (b >= 1 && b <= 8) dec_byte[b-1] = bus.tx;
                else if (b == 9) chk("stop_bit", bus.tx, 1);
            end
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.busy !== 1'b0 && n < limit) begin
            step();
            n++;
        end
        chk("idle_timeout", bus.busy, 0);
    endtask

    initial begin
        int n;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        // Reset values
        rst = 1'b1;
        repeat (3) step();
        chk("rst_tx", bus.tx, 1);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overflow", bus.overflow, 0);
        rst = 1'b0;
        step();

        // Single byte 0x55: alternating line, start bit two cycles after write
        bus.wr_en = 1'b1; bus.wr_data = 8'h55;
        step();
        bus.wr_en = 1'b0;
        chk("single_count", bus.count, 1);
        chk("single_tx_pre", bus.tx, 1);
        step();
        chk("single_level", bus.tx, 0);
        for (int i = 1; i < FRAME; i++) begin
            step();
            chk("single_level", bus.tx, (i / CPB) % 2);
        end
        chk("single_busy_stop", bus.busy, 1);
        step();
        chk("single_busy_end", bus.busy, 0);
        chk("single_decoded", dec_log[dec_log.size()-1], 8'h55);

        // Back-to-back 0xA5, 0x3C
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        step();
        chk("b2b_count0", bus.count, 1);
        bus.wr_data = 8'h3C;
        step();
        bus.wr_en = 1'b0;
        chk("b2b_count1", bus.count, 1);
        repeat (FRAME - 1) step();
        chk("b2b_count_last_stop", bus.count, 1);
        step();
        chk("b2b_count2", bus.count, 0);
        chk("b2b_no_gap", bus.tx, 0);
        repeat (FRAME - 1) step();
        chk("b2b_busy", bus.busy, 1);
        step();
        chk("b2b_idle", bus.busy, 0);
        n = dec_log.size();
        chk("b2b_byte0", dec_log[n-2], 8'hA5);
        chk("b2b_byte1", dec_log[n-1], 8'h3C);

        // Fill and overflow while a frame is on the line
        bus.wr_en = 1'b1; bus.wr_data = 8'hF0;
        step();
        bus.wr_en = 1'b0;
        step();
        for (int j = 1; j <= 5; j++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(j);
            step();
            chk("fill_count", bus.count, (j >= 4) ? 4 : j);
            chk("fill_full", bus.full, j >= 4);
            chk("fill_overflow", bus.overflow, j == 5);
        end
        bus.wr_en = 1'b0;
        wait_idle(7 * FRAME);
        n = dec_log.size();
        chk("fill_b0", dec_log[n-5], 8'hF0);
        for (int j = 1; j <= 4; j++) chk("fill_bn", dec_log[n-5+j], 8'(j));
        chk("fill_overflow_sticky", bus.overflow, 1);

        // Push landing exactly on the final STOP cycle
        bus.wr_en = 1'b1; bus.wr_data = 8'h81;
        step();
        bus.wr_en = 1'b0;
        step();
        repeat (FRAME - 1) step();
        bus.wr_en = 1'b1; bus.wr_data = 8'h7E;
        step();
        bus.wr_en = 1'b0;
        chk("laststop_tx_idle", bus.tx, 1);
        chk("laststop_count", bus.count, 1);
        chk("laststop_busy", bus.busy, 1);
        step();
        chk("laststop_start", bus.tx, 0);
        chk("laststop_popped", bus.count, 0);
        wait_idle(2 * FRAME);
        chk("laststop_decoded", dec_log[dec_log.size()-1], 8'h7E);

        // Reset during DATA bit 3 with two bytes queued
        bus.wr_en = 1'b1; bus.wr_data = 8'h11;
        step();
        bus.wr_data = 8'h22;
        step();
        bus.wr_data = 8'h33;
        step();
        bus.wr_en = 1'b0;
        chk("midrst_count_pre", bus.count, 2);
        repeat (44) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_tx", bus.tx, 1);
        chk("midrst_count", bus.count, 0);
        chk("midrst_overflow", bus.overflow, 0);
        chk("midrst_busy", bus.busy, 0);
        n = dec_log.size();
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            chk("midrst_line_quiet", bus.tx, 1);
        end
        chk("midrst_no_frames", dec_log.size(), n);

        // Randomized traffic against the model, including rare resets
        for (int c = 0; c < 3000; c++) begin
            bus.wr_en   = ($urandom_range(0, 99) < 4);
            bus.wr_data = 8'($urandom);
            rst         = ($urandom_range(0, 1499) == 0);
            step();
        end
        bus.wr_en = 1'b0;
        rst       = 1'b0;
        wait_idle((BS + 2) * FRAME);
        chk("rand_all_decoded", sent_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
